// File: rtl/exec_unit_if.sv
// Handshake and operand bundle between decode, the execute stage and memory.
// master = decode/memory side, slave = exec_unit.
interface exec_unit_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            a_sel;
  logic            b_sel;
  logic            op_imm;
  logic            pass_b;
  logic            is_m;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            br_eq;
  logic            br_lt;
  logic            br_ltu;
  logic            busy;

  modport master (
    output flush, in_valid, rs1, rs2, pc, imm, a_sel, b_sel, op_imm, pass_b,
           is_m, funct3, funct7, out_ready,
    input  in_ready, out_valid, result, br_eq, br_lt, br_ltu, busy
  );

  modport slave (
    input  flush, in_valid, rs1, rs2, pc, imm, a_sel, b_sel, op_imm, pass_b,
           is_m, funct3, funct7, out_ready,
    output in_ready, out_valid, result, br_eq, br_lt, br_ltu, busy
  );
endinterface

// File: rtl/exec_unit.sv
// RV32IM execute stage: single-cycle ALU, iterative shift-add multiply and
// restoring divide over operand magnitudes, with registered branch flags.
module exec_unit #(
  parameter int XLEN = 32
) (
  input logic       clock,
  input logic       reset,
  exec_unit_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic            eq_q, eq_d, lt_q, lt_d, ltu_q, ltu_d;
  logic            neg_q, neg_d, rneg_q, rneg_d, sel_q, sel_d;

  logic            accept;
  logic [XLEN-1:0] op_a, op_b, alu_res, mag_a, mag_b;
  logic [SHW-1:0]  shamt;
  logic            is_div, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN:0]   mul_sum, div_sh;
  logic [2*XLEN-1:0] mul_prod, mul_fin;
  logic            div_ge;
  logic [XLEN-1:0] div_sub, div_rem, div_quo, div_fin;
  logic            unused_f7;

  assign unused_f7 = ^{bus.funct7[6], bus.funct7[4:0]};

  assign accept        = bus.in_valid & bus.in_ready & ~bus.flush;
  assign bus.in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_MUL) | (state_q == S_DIV);
  assign bus.result    = res_q;
  assign bus.br_eq     = eq_q;
  assign bus.br_lt     = lt_q;
  assign bus.br_ltu    = ltu_q;

  assign op_a  = bus.a_sel ? bus.pc  : bus.rs1;
  assign op_b  = bus.b_sel ? bus.imm : bus.rs2;
  assign shamt = op_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (bus.funct3)
      3'd0: alu_res = (~bus.op_imm & bus.funct7[5]) ? op_a - op_b : op_a + op_b;
      3'd1: alu_res = op_a << shamt;
      3'd2: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      3'd3: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      3'd4: alu_res = op_a ^ op_b;
      3'd5: alu_res = bus.funct7[5] ? $unsigned($signed(op_a) >>> shamt) : op_a >> shamt;
      3'd6: alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase
    if (bus.pass_b) alu_res = op_b;
  end

  // Signedness per M op; plain MUL is run unsigned since its low half is sign-agnostic.
  assign is_div   = bus.funct3[2];
  assign sgn_a    = is_div ? ~bus.funct3[0] : (bus.funct3[1] ^ bus.funct3[0]);
  assign sgn_b    = is_div ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
  assign a_neg    = sgn_a & op_a[XLEN-1];
  assign b_neg    = sgn_b & op_b[XLEN-1];
  assign mag_a    = a_neg ? -op_a : op_a;
  assign mag_b    = b_neg ? -op_b : op_b;
  assign div_zero = (op_b == '0);
  assign div_ovf  = sgn_a & (op_a == MIN_NEG) & (op_b == '1);

  // Multiply step: {hi,lo} holds partial product above the remaining multiplier bits.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_prod = {mul_sum, lo_q[XLEN-1:1]};
  assign mul_fin  = neg_q ? -mul_prod : mul_prod;

  // Divide step: hi is the partial remainder, lo shifts dividend out and quotient in.
  assign div_sh  = {hi_q, lo_q[XLEN-1]};
  assign div_ge  = div_sh >= {1'b0, opnd_q};
  assign div_sub = div_sh[XLEN-1:0] - opnd_q;
  assign div_rem = div_ge ? div_sub : div_sh[XLEN-1:0];
  assign div_quo = {lo_q[XLEN-2:0], div_ge};
  assign div_fin = sel_q ? (rneg_q ? -div_rem : div_rem) : (neg_q ? -div_quo : div_quo);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    ltu_d   = ltu_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    sel_d   = sel_q;
    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      eq_d   = (bus.rs1 == bus.rs2);
      lt_d   = $signed(bus.rs1) < $signed(bus.rs2);
      ltu_d  = bus.rs1 < bus.rs2;
      neg_d  = a_neg ^ b_neg;
      rneg_d = a_neg;
      hi_d   = '0;
      if (!bus.is_m) begin
        res_d   = alu_res;
        state_d = S_DONE;
      end else if (!is_div) begin
        lo_d    = mag_b;
        opnd_d  = mag_a;
        sel_d   = (bus.funct3[1:0] != 2'b00);
        cnt_d   = CNT_LOAD;
        state_d = S_MUL;
      end else if (div_zero) begin
        res_d   = bus.funct3[1] ? op_a : '1;
        state_d = S_DONE;
      end else if (div_ovf) begin
        res_d   = bus.funct3[1] ? '0 : op_a;
        state_d = S_DONE;
      end else begin
        lo_d    = mag_a;
        opnd_d  = mag_b;
        sel_d   = bus.funct3[1];
        cnt_d   = CNT_LOAD;
        state_d = S_DIV;
      end
    end else begin
      case (state_q)
        S_MUL: begin
          hi_d  = mul_prod[2*XLEN-1:XLEN];
          lo_d  = mul_prod[XLEN-1:0];
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            res_d   = sel_q ? mul_fin[2*XLEN-1:XLEN] : mul_fin[XLEN-1:0];
            state_d = S_DONE;
          end
        end
        S_DIV: begin
          hi_d  = div_rem;
          lo_d  = div_quo;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            res_d   = div_fin;
            state_d = S_DONE;
          end
        end
        S_DONE: if (bus.out_ready) state_d = S_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      ltu_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      ltu_q   <= ltu_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      sel_q   <= sel_d;
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: arithmetic reference model plus a per-cycle
// scoreboard checking result, flags, latency and busy length.
module tb_exec_unit;
  logic clock;
  logic reset;

  exec_unit_if #(.XLEN(32)) bus ();
  exec_unit #(.XLEN(32)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  typedef struct packed {
    logic [31:0] res;
    logic        eq;
    logic        lt;
    logic        ltu;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  exp_t        exp_q[$];
  string       en_q[$];
  string       pn_q[$];
  logic [31:0] pa_q[$];
  logic [31:0] pe_q[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned busy_cnt = 0;
  bit          seen = 0;
  bit          done = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  function automatic logic [31:0] model_res(input logic [31:0] a, b, input logic opimm, passb, ism,
                                            input logic [2:0] f3, input logic [6:0] f7);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    model_res = '0;
    if (ism) begin
      case (f3)
        3'd0: begin p = ua * ub; model_res = p[31:0]; end
        3'd1: begin p = sa * sb; model_res = p[63:32]; end
        3'd2: begin p = sa * longint'(ub); model_res = p[63:32]; end
        3'd3: begin p = ua * ub; model_res = p[63:32]; end
        3'd4: model_res = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
        3'd5: model_res = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: model_res = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
        default: model_res = (b == 0) ? a : a % b;
      endcase
    end else if (passb) begin
      model_res = b;
    end else begin
      case (f3)
        3'd0: model_res = (!opimm && f7[5]) ? a - b : a + b;
        3'd1: model_res = a << b[4:0];
        3'd2: model_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: model_res = (a < b) ? 32'd1 : 32'd0;
        3'd4: model_res = a ^ b;
        3'd5: model_res = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: model_res = a | b;
        default: model_res = a & b;
      endcase
    end
  endfunction

  // Iterative ops take XLEN+1 cycles; everything else, including divide special cases, one.
  function automatic int unsigned model_lat(input logic [31:0] a, b, input logic ism, input logic [2:0] f3);
    if (!ism) return 1;
    if (!f3[2]) return 33;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic probe(input string n, input logic [31:0] act, input logic [31:0] req);
    pn_q.push_back(n);
    pa_q.push_back(act);
    pe_q.push_back(req);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ctl = {a_sel, b_sel, op_imm, pass_b, is_m}; must be called at posedge+#1.
  task automatic issue(input string nm, input logic [31:0] r1, r2, pcv, immv, input logic [4:0] ctl,
                       input logic [2:0] f3, input logic [6:0] f7, input bit push, input bit now,
                       input logic [31:0] lit);
    int unsigned waited;
    logic [31:0] a, b;
    exp_t e;
    bus.rs1 = r1; bus.rs2 = r2; bus.pc = pcv; bus.imm = immv;
    {bus.a_sel, bus.b_sel, bus.op_imm, bus.pass_b, bus.is_m} = ctl;
    bus.funct3 = f3; bus.funct7 = f7;
    bus.in_valid = 1'b1;
    waited = 0;
    @(negedge clock);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!bus.in_ready) begin
      probe({nm, "_accept_timeout"}, 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      step();
      return;
    end
    e.acc = cyc;
    step();
    bus.in_valid = 1'b0;
    if (push) begin
      a = ctl[4] ? pcv : r1;
      b = ctl[3] ? immv : r2;
      e.res = model_res(a, b, ctl[2], ctl[1], ctl[0], f3, f7);
      e.eq  = (r1 == r2);
      e.lt  = $signed(r1) < $signed(r2);
      e.ltu = r1 < r2;
      e.lat = model_lat(a, b, ctl[0], f3);
      exp_q.push_back(e);
      en_q.push_back(nm);
      probe({nm, "_model"}, e.res, lit);
    end
    if (now) probe({nm, "_ready_now"}, waited, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    probe("drain", exp_q.size(), 32'd0);
  endtask

  task automatic idle_state(input string nm);
    @(negedge clock);
    probe({nm, "_in_ready"},  {31'b0, bus.in_ready},  32'd1);
    probe({nm, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    probe({nm, "_busy"},      {31'b0, bus.busy},      32'd0);
    step();
  endtask

  initial begin
    bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
    bus.rs1 = '0; bus.rs2 = '0; bus.pc = '0; bus.imm = '0;
    bus.a_sel = 0; bus.b_sel = 0; bus.op_imm = 0; bus.pass_b = 0; bus.is_m = 0;
    bus.funct3 = '0; bus.funct7 = '0;
    reset = 1;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    idle_state("reset");
    @(negedge clock);
    probe("reset_result", bus.result, 32'd0);
    probe("reset_flags", {29'b0, bus.br_eq, bus.br_lt, bus.br_ltu}, 32'd0);
    step();

    issue("add", 32'd5, 32'd7, 0, 0, 5'b00000, 3'd0, 7'h00, 1, 1, 32'h0000_000C);
    issue("sub", 32'd5, 32'd7, 0, 0, 5'b00000, 3'd0, 7'h20, 1, 1, 32'hFFFF_FFFE);
    issue("sltu", 32'd1, 32'hFFFF_FFFF, 0, 0, 5'b00000, 3'd3, 7'h00, 1, 1, 32'd1);
    issue("slt", 32'd1, 32'hFFFF_FFFF, 0, 0, 5'b00000, 3'd2, 7'h00, 1, 1, 32'd0);
    issue("xor", 32'hA5A5_A5A5, 32'hFFFF_0000, 0, 0, 5'b00000, 3'd4, 7'h00, 1, 1, 32'h5A5A_A5A5);
    issue("addi_f7", 32'h10, 0, 0, 32'h400, 5'b01100, 3'd0, 7'h20, 1, 1, 32'h0000_0410);
    issue("lui", 0, 0, 0, 32'h1234_5000, 5'b01010, 3'd0, 7'h00, 1, 1, 32'h1234_5000);
    issue("auipc", 0, 0, 32'h1000, 32'h2000, 5'b11000, 3'd0, 7'h00, 1, 1, 32'h0000_3000);
    issue("sll33", 32'd3, 32'd33, 0, 0, 5'b00000, 3'd1, 7'h00, 1, 1, 32'd6);
    issue("srl31", 32'h8000_0000, 32'd31, 0, 0, 5'b00000, 3'd5, 7'h00, 1, 1, 32'd1);
    drain();

    issue("mul", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 5'b00001, 3'd0, 7'h01, 1, 1, 32'h0000_0001);
    issue("mulhu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 5'b00001, 3'd3, 7'h01, 1, 0, 32'hFFFF_FFFE);
    issue("mulh", 32'hFFFF_FFFE, 32'd3, 0, 0, 5'b00001, 3'd1, 7'h01, 1, 0, 32'hFFFF_FFFF);
    issue("mulhsu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 5'b00001, 3'd2, 7'h01, 1, 0, 32'hFFFF_FFFF);
    issue("div", 32'hFFFF_FFF9, 32'd2, 0, 0, 5'b00001, 3'd4, 7'h01, 1, 0, 32'hFFFF_FFFD);
    issue("rem", 32'hFFFF_FFF9, 32'd2, 0, 0, 5'b00001, 3'd6, 7'h01, 1, 0, 32'hFFFF_FFFF);
    issue("divu", 32'd100, 32'd7, 0, 0, 5'b00001, 3'd5, 7'h01, 1, 0, 32'd14);
    issue("remu", 32'd100, 32'd7, 0, 0, 5'b00001, 3'd7, 7'h01, 1, 0, 32'd2);
    issue("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 5'b00001, 3'd4, 7'h01, 1, 0, 32'h8000_0000);
    issue("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 5'b00001, 3'd6, 7'h01, 1, 1, 32'd0);
    issue("divu_z", 32'd7, 32'd0, 0, 0, 5'b00001, 3'd5, 7'h01, 1, 1, 32'hFFFF_FFFF);
    issue("remu_z", 32'd7, 32'd0, 0, 0, 5'b00001, 3'd7, 7'h01, 1, 1, 32'd7);
    drain();

    bus.out_ready = 0;
    issue("srai", 32'h8000_0000, 32'h8000_0000, 0, 32'd4, 5'b01100, 3'd5, 7'h20, 1, 1, 32'hF800_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      probe("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
      step();
    end
    bus.out_ready = 1;
    issue("add_after_hold", 32'd2, 32'd2, 0, 0, 5'b00000, 3'd0, 7'h00, 1, 1, 32'd4);
    drain();

    issue("div_flushed", 32'd1000, 32'd3, 0, 0, 5'b00001, 3'd4, 7'h01, 0, 0, 32'd0);
    repeat (9) step();
    bus.flush = 1;
    step();
    bus.flush = 0;
    idle_state("after_flush");
    bus.rs1 = 32'd1; bus.rs2 = 32'd1; bus.is_m = 0; bus.a_sel = 0; bus.b_sel = 0;
    bus.funct3 = 3'd0; bus.funct7 = 7'h00; bus.in_valid = 1; bus.flush = 1;
    step();
    bus.in_valid = 0; bus.flush = 0;
    idle_state("flush_blocks_accept");
    repeat (40) step();
    issue("add_post_flush", 32'd1, 32'd1, 0, 0, 5'b00000, 3'd0, 7'h00, 1, 1, 32'd2);
    drain();

    issue("mul_reset", 32'd12345, 32'd678, 0, 0, 5'b00001, 3'd0, 7'h01, 0, 0, 32'd0);
    repeat (9) step();
    reset = 1;
    step();
    reset = 0;
    idle_state("after_reset");
    @(negedge clock);
    probe("after_reset_result", bus.result, 32'd0);
    probe("after_reset_flags", {29'b0, bus.br_eq, bus.br_lt, bus.br_ltu}, 32'd0);
    step();
    repeat (40) step();
    issue("add_post_reset", 32'd1, 32'd1, 0, 0, 5'b00000, 3'd0, 7'h00, 1, 1, 32'd2);
    drain();
    repeat (2) step();
    done = 1;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", n, act, req);
    end
  endtask

  always @(negedge clock) begin
    exp_t cur;
    string nm;
    while (pn_q.size() != 0) chk(pn_q.pop_front(), pa_q.pop_front(), pe_q.pop_front());
    if (exp_q.size() == 0) begin
      busy_cnt = 0;
      seen = 0;
      chk("no_spurious_valid", {31'b0, bus.out_valid}, 32'd0);
    end else begin
      cur = exp_q[0];
      nm = en_q[0];
      if (bus.busy) busy_cnt++;
      if (bus.out_valid) begin
        chk({nm, "_result"}, bus.result, cur.res);
        chk({nm, "_flags"}, {29'b0, bus.br_eq, bus.br_lt, bus.br_ltu}, {29'b0, cur.eq, cur.lt, cur.ltu});
        if (!seen) begin
          chk({nm, "_latency"}, cyc - cur.acc, cur.lat);
          chk({nm, "_busy_cycles"}, busy_cnt, cur.lat - 1);
          seen = 1;
        end
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          void'(en_q.pop_front());
          seen = 0;
          busy_cnt = 0;
        end
      end
    end
    if (done) begin
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end
endmodule
